// File: rtl/dec_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dec_scan_ctrl : sequences a 3-to-8 decoder select (W/En) up or down with a
//                 per-step dwell, single-pass or looping. Rev 1.0
// ----------------------------------------------------------------------------
module dec_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               loop,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         W,
  output logic               En,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state, w_state;
  logic [2:0]           r_w, w_w;
  logic                 r_en, w_en;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic [DWELL_W-1:0]   r_cnt, w_cnt;
  logic [DWELL_W-1:0]   r_dwell, w_dwell;
  logic                 r_dir, w_dir;
  logic                 r_loop, w_loop;
  logic                 w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_w     <= 3'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_dwell <= '0;
      r_dir   <= 1'b0;
      r_loop  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_w     <= w_w;
      r_en    <= w_en;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cnt   <= w_cnt;
      r_dwell <= w_dwell;
      r_dir   <= w_dir;
      r_loop  <= w_loop;
    end
  end

  // Final select value of a pass depends on the latched direction only.
  assign w_last = r_dir ? (r_w == 3'd0) : (r_w == 3'd7);

  always_comb begin
    w_state = r_state;
    w_w     = r_w;
    w_en    = r_en;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_cnt   = r_cnt;
    w_dwell = r_dwell;
    w_dir   = r_dir;
    w_loop  = r_loop;
    case (r_state)
      IDLE: begin
        w_w    = 3'd0;
        w_en   = 1'b0;
        w_busy = 1'b0;
        w_cnt  = '0;
        if (start && !stop) begin
          w_state = SCAN;
          w_dir   = dir;
          w_loop  = loop;
          w_dwell = dwell;
          w_w     = dir ? 3'd7 : 3'd0;
          w_en    = 1'b1;
          w_busy  = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          w_state = IDLE;
          w_w     = 3'd0;
          w_en    = 1'b0;
          w_busy  = 1'b0;
          w_cnt   = '0;
        end else if (r_cnt == r_dwell) begin
          w_cnt = '0;
          if (w_last && !r_loop) begin
            w_state = DONE;
            w_en    = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            // 3-bit arithmetic gives the 7->0 / 0->7 wrap for free.
            w_w = r_dir ? (r_w - 3'd1) : (r_w + 3'd1);
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state = IDLE;
        w_w     = 3'd0;
        w_en    = 1'b0;
        w_busy  = 1'b0;
        w_cnt   = '0;
      end
      default: begin
        w_state = IDLE;
        w_w     = 3'd0;
        w_en    = 1'b0;
        w_busy  = 1'b0;
        w_cnt   = '0;
      end
    endcase
  end

  assign W    = r_w;
  assign En   = r_en;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dec_scan_ctrl : directed self-checking bench for dec_scan_ctrl. Rev 1.0
// ----------------------------------------------------------------------------
module tb_dec_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, dir, loop;
  logic [3:0] dwell;
  logic [2:0] W;
  logic       En, busy, done;

  int n_checks = 0;
  int n_errs   = 0;

  dec_scan_ctrl #(.DWELL_W(4)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .dir   (dir),
    .loop  (loop),
    .dwell (dwell),
    .W     (W),
    .En    (En),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Packs {W, En, busy, done} for a single comparison.
  function automatic logic [31:0] pk(input logic [2:0] w, input logic en, input logic b, input logic d);
    return {26'd0, w, en, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] w, input logic en, input logic b, input logic d);
    check_val(tag, pk(W, En, busy, done), pk(w, en, b, d));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; loop = 1'b0; dwell = 4'd0;
    #2;
    chk("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Up single pass, dwell 0, with a start pulse mid-scan and during DONE.
    dir = 1'b0; loop = 1'b0; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("up_step", 3'(i), 1'b1, 1'b1, 1'b0);
      start = (i == 3);
      tick();
    end
    chk("up_done", 3'd7, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("up_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("no_restart", 3'd0, 1'b0, 1'b0, 1'b0);

    // Down single pass, dwell 2; inputs changed mid-scan must not matter.
    dir = 1'b1; dwell = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("down_step", 3'(7 - i / 3), 1'b1, 1'b1, 1'b0);
      if (i == 5) begin dir = 1'b0; dwell = 4'd0; loop = 1'b1; end
      tick();
    end
    chk("down_done", 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("down_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Loop mode, 20 cycles, then stop.
    dir = 1'b0; loop = 1'b1; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("loop_step", 3'(i % 8), 1'b1, 1'b1, 1'b0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("loop_nodone", 3'd0, 1'b0, 1'b0, 1'b0);

    // start+stop together in IDLE.
    loop = 1'b0; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop", 3'd0, 1'b0, 1'b0, 1'b0);

    // Stop on the final step cycle beats the DONE transition.
    dir = 1'b0; loop = 1'b0; dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_final", 3'd7, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("final_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("final_nodone", 3'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges mid-scan.
    dwell = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst", 3'd1, 1'b1, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    tick(); tick();
    chk("post_rst", 3'd0, 1'b0, 1'b0, 1'b0);

    // Maximum dwell: 16 cycles per step.
    dwell = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("dwell15_w0", 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("dwell15_w1", 3'd1, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("dwell15_stop", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dec_scan_ctrl.md
DEC_SCAN_CTRL -- requirements
Module: dec_scan_ctrl

Interface
REQ-001 Parameter: DWELL_W, default 4, width of the per-step dwell count.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  scan request, sampled on the clk edge.
REQ-005 Port: stop  input  1  abort request, sampled on the clk edge.
REQ-006 Port: dir  input  1  0 = up scan (0..7); 1 = down scan (7..0).
REQ-007 Port: loop  input  1  1 = wrap continuously; 0 = single pass.
REQ-008 Port: dwell  input  DWELL_W  extra cycles each select value is held.
REQ-009 Port: W  output  3  decoder select; feeds the 3-to-8 decoder W input directly.
REQ-010 Port: En  output  1  decoder enable; feeds the decoder En input directly.
REQ-011 Port: busy  output  1  high while a scan is active.
REQ-012 Port: done  output  1  single-cycle pulse at the end of a completed single-pass scan.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from input to output.
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-015 IDLE SHALL drive En=0, W=0, busy=0 and done=0.
REQ-016 In IDLE, start=1 with stop=0 SHALL move the FSM to SCAN on that edge.
REQ-017 On that same edge the block SHALL latch dir, loop and dwell, set W to 0 (up) or 7 (down), set En=1 and set busy=1.
REQ-018 Each W value SHALL be held for exactly dwell+1 cycles, so dwell=0 gives one cycle per step.
REQ-019 On expiry of the dwell, W SHALL step +1 (up) or -1 (down) using 3-bit arithmetic.
REQ-020 Changes to dir, loop or dwell during SCAN SHALL be ignored until the next start.
REQ-021 Single pass (loop=0): after the last value (7 up, 0 down) completes its dwell, the FSM SHALL enter DONE.
REQ-022 The single-pass En-high period SHALL be exactly 8*(dwell+1) cycles.
REQ-023 Loop mode (loop=1): after the last value completes its dwell, W SHALL wrap (7->0 up, 0->7 down) with no gap cycle, and done SHALL never assert.
REQ-024 DONE SHALL last exactly one cycle with done=1, En=0, busy=0 and W holding the last value, then return to IDLE.
REQ-025 stop=1 in SCAN SHALL move the FSM to IDLE on that edge (En=0, W=0, busy=0), with no done pulse.
REQ-026 stop SHALL take priority over a dwell expiry or final step occurring in the same cycle.
REQ-027 start=1 and stop=1 together in IDLE SHALL leave the FSM in IDLE.
REQ-028 start during SCAN or DONE SHALL be ignored, and no scan restart SHALL occur.
REQ-029 stop in DONE or IDLE SHALL have no effect.
REQ-030 The dwell counter SHALL be DWELL_W bits wide, and dwell = all-ones SHALL give 2^DWELL_W cycles per step without overflow.
REQ-031 En SHALL never be high while the FSM is in IDLE or DONE.
REQ-032 W SHALL change only on edges where En is already low or a step boundary occurs, never mid-dwell.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for clk, force IDLE with W=0, En=0, busy=0, done=0 and the dwell counter cleared.
REQ-034 rst asserted mid-SCAN SHALL abort the scan with no done pulse.
REQ-035 After rst deasserts, the block SHALL wait in IDLE for a fresh start.
REQ-036 Latched dir, loop and dwell SHALL reset to 0.

Verification
REQ-037 Up scan, single pass: dir=0, loop=0, dwell=0, start pulse -> W=0,1,...,7 on consecutive cycles with En=1 for 8 cycles, then done=1 for 1 cycle, then IDLE.
REQ-038 Down scan with dwell: dir=1, dwell=2 -> W=7,7,7,6,6,6,...,0,0,0 with En high for 24 cycles, then one done pulse.
REQ-039 Loop and stop: loop=1, dwell=0, run 20 cycles -> W sequence 0..7,0..7,0..3 with no done pulse; stop -> next cycle En=0, W=0, busy=0, still no done.
REQ-040 Simultaneous events: start+stop in IDLE -> stays IDLE; start during SCAN -> scan sequence unchanged; stop on the final step cycle -> IDLE with no done.
REQ-041 Async reset: assert rst mid-SCAN between clk edges -> W=0, En=0, busy=0 before the next edge; after release, no activity until start.
REQ-042 Latching: change dwell and dir mid-scan -> step timing and direction unchanged; dwell=15 -> each W held for 16 cycles.
